// File: rtl/l2_ifill_responder.sv
// Instruction-cache refill responder: holds one cache line and, on a miss,
// fetches it beat by beat from a narrow backing memory.
//
// state | meaning
// IDLE  | line held (or none); compare requests against line_base
// FETCH | reading beats 0..NBEATS-1 of line_base from backing memory
module l2_ifill_responder #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       req_addr,
    input  logic              req_re,
    input  logic              flush,
    output logic              busy,
    output logic [LINE_W-1:0] block_out,
    output logic [31:0]       mem_addr,
    output logic              mem_re,
    input  logic [BEAT_W-1:0] mem_rdata,
    input  logic              mem_valid
);

    localparam int NBEATS = LINE_W / BEAT_W;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t            state, state_nxt;
    logic [26:0]       line_base;
    logic              line_valid;
    logic              abort;
    logic [BW-1:0]     beat;
    logic [LINE_W-1:0] buffer;

    logic hit;
    logic miss_start;
    logic last_beat;

    assign hit        = line_valid && (req_addr[31:5] == line_base) && !flush;
    assign miss_start = (state == IDLE) && req_re && !hit;
    assign last_beat  = (state == FETCH) && mem_valid && (beat == BW'(NBEATS - 1));
    assign block_out  = buffer;

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = 32'h0;
        case (state)
            IDLE: begin
                busy = req_re && !hit;
                if (miss_start)
                    state_nxt = FETCH;
            end
            FETCH: begin
                busy     = 1'b1;
                mem_re   = 1'b1;
                mem_addr = {line_base, 5'b0} + (32'(beat) << 2);
                if (last_beat)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            line_base  <= 27'h0;
            line_valid <= 1'b0;
            abort      <= 1'b0;
            beat       <= '0;
            buffer     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (miss_start) begin
                        line_base  <= req_addr[31:5];
                        beat       <= '0;
                        abort      <= 1'b0;
                        line_valid <= 1'b0;
                    end else if (flush) begin
                        line_valid <= 1'b0;
                    end
                end
                FETCH: begin
                    // A flush mid-fill still lets the fill finish but poisons the result.
                    if (flush)
                        abort <= 1'b1;
                    if (mem_valid) begin
                        buffer[int'(beat)*BEAT_W +: BEAT_W] <= mem_rdata;
                        beat <= beat + BW'(1);
                        if (last_beat)
                            line_valid <= !abort && !flush;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_ifill_responder.sv
// Directed bench for l2_ifill_responder: cold miss, hit, wait states,
// flush and reset during a fill, request address change during a fill.
module tb_l2_ifill_responder;

    localparam int LINE_W = 256;
    localparam int BEAT_W = 32;

    logic              clk;
    logic              rst_n;
    logic [31:0]       req_addr;
    logic              req_re;
    logic              flush;
    logic              busy;
    logic [LINE_W-1:0] block_out;
    logic [31:0]       mem_addr;
    logic              mem_re;
    logic [BEAT_W-1:0] mem_rdata;
    logic              mem_valid;

    int vectors;
    int miscompares;

    l2_ifill_responder #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_addr  (req_addr),
        .req_re    (req_re),
        .flush     (flush),
        .busy      (busy),
        .block_out (block_out),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory returns the word's own byte address as data.
    function automatic logic [LINE_W-1:0] line_of(input logic [31:0] base);
        logic [LINE_W-1:0] l;
        l = '0;
        for (int k = 0; k < 8; k++)
            l[32*k +: 32] = base + 32'(4*k);
        return l;
    endfunction

    // Entered in the first FETCH cycle; leaves in the cycle after the last beat.
    task automatic run_fill(input logic [31:0] base, input int gap, input int flush_beat,
                            input int move_beat, input logic [31:0] move_addr);
        for (int k = 0; k < 8; k++) begin
            for (int w = 0; w <= gap; w++) begin
                mem_valid = (w == gap);
                mem_rdata = base + 32'(4*k);
                flush     = (k == flush_beat) && (w == gap);
                if (k == move_beat)
                    req_addr = move_addr;
                #1;
                chk("fill_mem_addr", LINE_W'(mem_addr), LINE_W'(base + 32'(4*k)));
                chk("fill_mem_re", LINE_W'(mem_re), LINE_W'(1'b1));
                chk("fill_busy", LINE_W'(busy), LINE_W'(1'b1));
                step();
            end
        end
        mem_valid = 1'b0;
        flush     = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n     = 1'b0;
        req_re    = 1'b0;
        req_addr  = 32'h0;
        flush     = 1'b0;
        mem_valid = 1'b0;
        mem_rdata = '0;

        #3;
        chk("rst_block_out", block_out, '0);
        chk("rst_mem_re", LINE_W'(mem_re), LINE_W'(1'b0));
        chk("rst_mem_addr", LINE_W'(mem_addr), LINE_W'(32'h0));
        chk("rst_busy_idle", LINE_W'(busy), LINE_W'(1'b0));
        req_re = 1'b1;
        #1;
        chk("rst_busy_req", LINE_W'(busy), LINE_W'(1'b1));
        req_re = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // cold miss
        req_addr = 32'h0000_1044;
        req_re   = 1'b1;
        #1;
        chk("cold_busy_c0", LINE_W'(busy), LINE_W'(1'b1));
        chk("cold_mem_re_c0", LINE_W'(mem_re), LINE_W'(1'b0));
        step();
        run_fill(32'h1040, 0, -1, -1, 32'h0);
        #1;
        chk("cold_busy_c9", LINE_W'(busy), LINE_W'(1'b0));
        chk("cold_mem_re_c9", LINE_W'(mem_re), LINE_W'(1'b0));
        chk("cold_line", block_out, line_of(32'h1040));

        // hit
        req_addr = 32'h0000_105C;
        #1;
        chk("hit_busy", LINE_W'(busy), LINE_W'(1'b0));
        chk("hit_mem_re", LINE_W'(mem_re), LINE_W'(1'b0));
        step();
        chk("hit_mem_re_next", LINE_W'(mem_re), LINE_W'(1'b0));
        chk("hit_line", block_out, line_of(32'h1040));

        // wait states
        req_addr = 32'h0000_2000;
        #1;
        chk("wait_busy_c0", LINE_W'(busy), LINE_W'(1'b1));
        step();
        run_fill(32'h2000, 2, -1, -1, 32'h0);
        #1;
        chk("wait_busy_done", LINE_W'(busy), LINE_W'(1'b0));
        chk("wait_line", block_out, line_of(32'h2000));

        // flush mid-fill
        req_addr = 32'h0000_3000;
        #1;
        chk("flush_busy_c0", LINE_W'(busy), LINE_W'(1'b1));
        step();
        run_fill(32'h3000, 0, 3, -1, 32'h0);
        #1;
        chk("flush_remiss_busy", LINE_W'(busy), LINE_W'(1'b1));
        chk("flush_line_data", block_out, line_of(32'h3000));
        step();
        chk("flush_refetch_re", LINE_W'(mem_re), LINE_W'(1'b1));
        chk("flush_refetch_addr", LINE_W'(mem_addr), LINE_W'(32'h3000));

        // reset during beat 5 of the refetch
        for (int k = 0; k < 5; k++) begin
            mem_valid = 1'b1;
            mem_rdata = 32'h3000 + 32'(4*k);
            #1;
            chk("rstmid_mem_addr", LINE_W'(mem_addr), LINE_W'(32'h3000 + 32'(4*k)));
            step();
        end
        mem_rdata = 32'h3014;
        rst_n = 1'b0;
        #1;
        chk("rstmid_mem_re", LINE_W'(mem_re), LINE_W'(1'b0));
        chk("rstmid_block_out", block_out, '0);
        chk("rstmid_mem_addr", LINE_W'(mem_addr), LINE_W'(32'h0));
        chk("rstmid_busy", LINE_W'(busy), LINE_W'(1'b1));
        step();
        chk("rstmid_late_valid", block_out, '0);
        rst_n     = 1'b1;
        mem_valid = 1'b0;
        #1;
        chk("rstmid_remiss_busy", LINE_W'(busy), LINE_W'(1'b1));
        step();
        run_fill(32'h3000, 0, -1, -1, 32'h0);
        #1;
        chk("rstmid_busy_done", LINE_W'(busy), LINE_W'(1'b0));
        chk("rstmid_line", block_out, line_of(32'h3000));

        // request address moves during the fill
        req_addr = 32'h0000_4000;
        #1;
        chk("move_busy_c0", LINE_W'(busy), LINE_W'(1'b1));
        step();
        run_fill(32'h4000, 0, -1, 2, 32'h0000_5000);
        #1;
        chk("move_new_miss", LINE_W'(busy), LINE_W'(1'b1));
        chk("move_idle_re", LINE_W'(mem_re), LINE_W'(1'b0));
        chk("move_line_4000", block_out, line_of(32'h4000));
        step();
        run_fill(32'h5000, 0, -1, -1, 32'h0);
        #1;
        chk("move_busy_done", LINE_W'(busy), LINE_W'(1'b0));
        chk("move_line_5000", block_out, line_of(32'h5000));

        // flush in IDLE
        req_re = 1'b0;
        flush  = 1'b1;
        #1;
        chk("iflush_busy_nore", LINE_W'(busy), LINE_W'(1'b0));
        req_re = 1'b1;
        #1;
        chk("iflush_forced_miss", LINE_W'(busy), LINE_W'(1'b1));
        req_re = 1'b0;
        step();
        flush  = 1'b0;
        req_re = 1'b1;
        #1;
        chk("iflush_invalidated", LINE_W'(busy), LINE_W'(1'b1));
        chk("iflush_line_kept", block_out, line_of(32'h5000));
        req_re = 1'b0;
        #1;
        chk("iflush_busy_idle", LINE_W'(busy), LINE_W'(1'b0));
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
